// File: rtl/fetch_pkg.sv
// Fetch-stage types and constants.
package fetch_pkg;

  typedef logic [31:0] t_fetch_pc;

  localparam int FETCH_INSTR_BYTES = 4;

  function automatic t_fetch_pc align_pc(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_pkg.sv
// Instruction packet carried from fetch to decode.
// Define SIMULATION to attach a per-instruction fetch id (SIMID).
package instr;

  typedef logic [31:0] t_rv_instr;

`ifdef SIMULATION
  typedef struct packed {
    logic [31:0] fid;
  } t_simid;
`endif

  typedef struct packed {
    t_rv_instr   instr;
    logic [31:0] pc;
`ifdef SIMULATION
    t_simid      simid;
`endif
  } t_instr_pkt;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two, >= 2.
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           full;

  assign full = (count == CW'(DEPTH));
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch.sv
// Instruction fetch: sequential PC generation, in-order fetch queue, redirect flush.
// Define FETCH_BYPASS_EN to let a response reach decode in its arrival cycle.
module fetch import instr::*; import fetch_pkg::*; #(
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        stall,
  output logic        valid_fe1,
  output t_instr_pkt  instr_fe1
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  // Extra bit: dropped and live requests can be outstanding together.
  localparam int IW = CW + 1;

  t_fetch_pc      pc;
  logic [IW-1:0]  inflight;
  logic [IW-1:0]  inflight_next;
  logic [IW-1:0]  drop_cnt;
  logic [IW:0]    occupancy;
  logic [CW-1:0]  q_count;
  logic [CW-1:0]  pcq_count;
  t_instr_pkt     q_head;
  t_instr_pkt     rsp_pkt;
  t_fetch_pc      pcq_head;
  logic           req_fire;
  logic           rsp_keep;
  logic           q_has;
  logic           bypass;
  logic           q_push;
  logic           q_pop;

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign rsp_keep  = mem_rsp_valid & (drop_cnt == '0);
  assign q_has     = (q_count != '0);
  assign occupancy = (IW+1)'(q_count) + (IW+1)'(inflight) - (IW+1)'(drop_cnt);

  assign mem_req_valid = ~reset & ~redirect_valid & (occupancy < (IW+1)'(FQ_DEPTH));
  assign mem_req_addr  = pc;
  assign inflight_next = inflight + IW'(req_fire) - IW'(mem_rsp_valid);

`ifdef FETCH_BYPASS_EN
  assign bypass = ~q_has & rsp_keep & ~redirect_valid & ~reset;
`else
  assign bypass = 1'b0;
`endif

`ifdef SIMULATION
  logic [31:0] fid_cnt;

  always_ff @(posedge clk) begin
    if (reset)                           fid_cnt <= '0;
    else if (rsp_keep && !redirect_valid) fid_cnt <= fid_cnt + 32'd1;
  end
`endif

  always_comb begin
    rsp_pkt       = '0;
    rsp_pkt.instr = mem_rsp_data;
    rsp_pkt.pc    = pcq_head;
`ifdef SIMULATION
    rsp_pkt.simid.fid = fid_cnt;
`endif
  end

  assign valid_fe1 = (q_has | bypass) & ~redirect_valid & ~reset;
  assign instr_fe1 = !valid_fe1 ? '0 : (q_has ? q_head : rsp_pkt);
  assign q_pop     = valid_fe1 & ~stall & q_has;
  // A bypassed response that decode takes immediately never occupies a slot.
  assign q_push    = rsp_keep & ~(bypass & ~stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        pc       <= align_pc(redirect_pc);
        drop_cnt <= inflight_next;
      end else begin
        if (req_fire) pc <= pc + 32'(FETCH_INSTR_BYTES);
        if (mem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(.T(t_instr_pkt), .DEPTH(FQ_DEPTH)) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (rsp_pkt),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  fetch_fifo #(.T(t_fetch_pc), .DEPTH(FQ_DEPTH)) u_pc_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep & (pcq_count != '0)),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
    mem_rsp_valid |-> (inflight != '0));

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (valid_fe1 && stall) |=> (!valid_fe1 || $stable(instr_fe1)));

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch with an in-order memory model and an expected-instruction scoreboard.
module tb_fetch;
  import instr::*;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        stall;
  logic        valid_fe1;
  t_instr_pkt  instr_fe1;

  always #5 clk = ~clk;

  fetch #(.FQ_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .stall          (stall),
    .valid_fe1      (valid_fe1),
    .instr_fe1      (instr_fe1)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } t_req;

  int          checks   = 0;
  int          failures = 0;
  t_req        pend[$];
  logic [31:0] exp_pc[$];
  logic [31:0] deq_log[$];
  int          epoch  = 0;
  bit          rsp_en = 1'b0;

  bit          s_valid, s_hs, s_req_valid;
  logic [31:0] s_pc, s_ins, s_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive responses, sample/score at negedge, update memory model after posedge.
  task automatic step();
    logic [31:0] e;
    mem_rsp_valid = rsp_en && !reset && (pend.size() > 0);
    mem_rsp_data  = (pend.size() > 0) ? ~pend[0].addr : 32'h0;
    @(negedge clk);
    s_valid     = valid_fe1;
    s_pc        = instr_fe1.pc;
    s_ins       = instr_fe1.instr;
    s_req_valid = mem_req_valid;
    s_addr      = mem_req_addr;
    s_hs        = mem_req_valid && mem_req_ready;
    if (mem_rsp_valid && !redirect_valid && pend[0].ep == epoch)
      exp_pc.push_back(pend[0].addr);
    if (reset || redirect_valid) begin
      check("flush_valid", 32'(valid_fe1), 32'd0);
    end else if (valid_fe1 && !stall) begin
      if (exp_pc.size() == 0) begin
        check("unexpected_valid", 32'(valid_fe1), 32'd0);
      end else begin
        e = exp_pc.pop_front();
        check("deq_pc", instr_fe1.pc, e);
        check("deq_instr", instr_fe1.instr, ~e);
        deq_log.push_back(instr_fe1.pc);
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      pend.delete();
      exp_pc.delete();
      epoch++;
    end else begin
      if (mem_rsp_valid) pend.delete(0);
      if (redirect_valid) begin
        exp_pc.delete();
        epoch++;
      end
      if (s_hs) pend.push_back('{addr: s_addr, ep: epoch});
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    rsp_en         = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int  first;
    int  nhs;
    bit  seen;

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_req_ready = 1'b0; stall = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;

    // Reset state
    step();
    check("rst_req_valid", 32'(s_req_valid), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_instr", s_ins, 32'd0);
    check("rst_pc", s_pc, 32'd0);
    step();
    reset = 1'b0;

    // Streaming
    mem_req_ready = 1'b1; rsp_en = 1'b1; stall = 1'b0;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 0) check("stream_first_addr", s_addr, 32'h0);
      if (s_valid && first < 0) first = c;
      if (c >= LAT && c < LAT + 4) begin
        check("stream_valid", 32'(s_valid), 32'd1);
        check("stream_pc", s_pc, 32'((c - LAT) * 4));
      end
    end
    check("stream_first_latency", 32'(first), 32'(LAT));

    // Backpressure
    do_reset();
    stall = 1'b1; rsp_en = 1'b1; mem_req_ready = 1'b1;
    nhs = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (s_hs) nhs++;
    end
    check("bp_requests", 32'(nhs), 32'd4);
    check("bp_req_valid_low", 32'(s_req_valid), 32'd0);
    stall = 1'b0;
    deq_log.delete();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_hs && !seen) begin
        check("bp_resume_addr", s_addr, 32'h10);
        seen = 1'b1;
      end
    end
    check("bp_resume_seen", 32'(seen), 32'd1);
    check("bp_drain_len", 32'(deq_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < deq_log.size()) check("bp_drain_pc", deq_log[i], 32'(i * 4));

    // Redirect with one queued and three outstanding
    do_reset();
    stall = 1'b1; rsp_en = 1'b0; mem_req_ready = 1'b1;
    repeat (6) step();
    rsp_en = 1'b1;
    step();
    rsp_en = 1'b0;
    step();
    check("rd_setup_credit", 32'(s_req_valid), 32'd0);
    check("rd_setup_count", 32'(dut.q_count), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    check("rd_cycle_req", 32'(s_req_valid), 32'd0);
    check("rd_drop_cnt", 32'(dut.drop_cnt), 32'd3);
    redirect_valid = 1'b0; stall = 1'b0; rsp_en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) begin
        check("rd_after_valid", 32'(s_valid), 32'd0);
        check("rd_after_addr", s_addr, 32'h100);
      end
      if (s_valid && !seen) begin
        check("rd_first_pc", s_pc, 32'h100);
        seen = 1'b1;
      end
    end
    check("rd_first_seen", 32'(seen), 32'd1);

    // Redirect coinciding with a response
    do_reset();
    stall = 1'b0; rsp_en = 1'b0; mem_req_ready = 1'b1;
    repeat (6) step();
    redirect_valid = 1'b1; redirect_pc = 32'h200; rsp_en = 1'b1;
    step();
    check("rr_cycle_valid", 32'(s_valid), 32'd0);
    check("rr_drop_cnt", 32'(dut.drop_cnt), 32'd3);
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_valid && !seen) begin
        check("rr_first_pc", s_pc, 32'h200);
        seen = 1'b1;
      end
    end
    check("rr_first_seen", 32'(seen), 32'd1);

    // Memory not ready
    do_reset();
    mem_req_ready = 1'b0; rsp_en = 1'b1; stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("nr_addr_hold", s_addr, 32'h0);
      check("nr_req_valid", 32'(s_req_valid), 32'd1);
    end
    mem_req_ready = 1'b1;
    step();
    check("nr_accept", 32'(s_hs), 32'd1);
    check("nr_accept_addr", s_addr, 32'h0);
    step();
    check("nr_next_addr", s_addr, 32'h4);
    repeat (4) step();

    // Reset mid-stream with three queued
    do_reset();
    stall = 1'b1; rsp_en = 1'b1; mem_req_ready = 1'b1;
    repeat (4) step();
    check("mid_count", 32'(dut.q_count), 32'd3);
    reset = 1'b1; rsp_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("mid_valid", 32'(s_valid), 32'd0);
    check("mid_addr", s_addr, 32'h0);
    check("mid_accept", 32'(s_hs), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
